spell_dbg_host: RTL

Host-side master for the SPELL core's serial debug port. It turns single-word commands (write register, read register, run, run-and-wait) into the core's pin-level sequences: MSB-first serial shift-in, load/dump strobes, register select, and run/step pulses. For reads it de-serializes the core's shift-out stream. It sits between a test/management controller (or a future on-chip loader) and the core's debug inputs and outputs, so software never bit-bangs the port.

---
 rtl/spell_dbg_host.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spell_dbg_host.sv
// spell_dbg_host: command-driven master for the SPELL core serial debug port.
// Turns write/read/run/run-wait words into shift, strobe and pulse sequences.
module spell_dbg_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       dbg_run,
  output logic       dbg_step,
  output logic       dbg_load,
  output logic       dbg_dump,
  output logic       dbg_shift_in,
  output logic [1:0] dbg_reg_sel,
  input  logic       dbg_shift_out,
  input  logic       dbg_stop
);

  typedef enum logic [3:0] {
    IDLE,
    SHIFT,
    LOAD,
    DUMP,
    CAPTURE,
    PULSE,
    WAIT_LOW,
    WAIT_HIGH,
    RESP
  } state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_RUNW = 2'b11;

  localparam logic [23:0] TMO = 24'(TIMEOUT_CYCLES);

  state_t      state;
  logic [1:0]  op;
  logic [7:0]  sh;
  logic [2:0]  cnt;
  logic        skip;
  logic [23:0] tcnt;
  logic [23:0] tcnt_nxt;

  assign cmd_ready = (state == IDLE);
  assign tcnt_nxt  = tcnt + 24'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op           <= OP_WR;
      sh           <= '0;
      cnt          <= '0;
      skip         <= 1'b0;
      tcnt         <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      dbg_run      <= 1'b0;
      dbg_step     <= 1'b0;
      dbg_load     <= 1'b0;
      dbg_dump     <= 1'b0;
      dbg_shift_in <= 1'b0;
      dbg_reg_sel  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op <= cmd_op;
            unique case (cmd_op)
              OP_WR: begin
                state        <= SHIFT;
                dbg_reg_sel  <= cmd_reg;
                dbg_shift_in <= cmd_data[7];
                sh           <= {cmd_data[6:0], 1'b0};
                cnt          <= '0;
              end
              OP_RD: begin
                state       <= DUMP;
                dbg_dump    <= 1'b1;
                dbg_reg_sel <= cmd_reg;
              end
              default: begin
                state    <= PULSE;
                dbg_run  <= 1'b1;
                dbg_step <= cmd_data[0];
              end
            endcase
          end
        end
        SHIFT: begin
          if (cnt == 3'd7) begin
            state        <= LOAD;
            dbg_shift_in <= 1'b0;
            dbg_load     <= 1'b1;
          end else begin
            dbg_shift_in <= sh[7];
            sh           <= {sh[6:0], 1'b0};
            cnt          <= cnt + 3'd1;
          end
        end
        LOAD: begin
          dbg_load    <= 1'b0;
          dbg_reg_sel <= '0;
          state       <= RESP;
          rsp_valid   <= 1'b1;
          rsp_data    <= '0;
        end
        DUMP: begin
          dbg_dump    <= 1'b0;
          dbg_reg_sel <= '0;
          state       <= CAPTURE;
          skip        <= 1'b1;
          cnt         <= '0;
        end
        // first CAPTURE cycle lets the core put its MSB on the line
        CAPTURE: begin
          if (skip) begin
            skip <= 1'b0;
          end else begin
            sh  <= {sh[6:0], dbg_shift_out};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= {sh[6:0], dbg_shift_out};
            end
          end
        end
        PULSE: begin
          dbg_run <= 1'b0;
          tcnt    <= '0;
          if (op == OP_RUNW) begin
            state <= WAIT_LOW;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
          end
        end
        WAIT_LOW: begin
          tcnt <= tcnt_nxt;
          if (!dbg_stop) begin
            state <= WAIT_HIGH;
          end else if (tcnt_nxt == TMO) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h01;
          end
        end
        WAIT_HIGH: begin
          tcnt <= tcnt_nxt;
          if (dbg_stop) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h00;
          end else if (tcnt_nxt == TMO) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h01;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
